idct_1d: RTL and testbench



---
 rtl/idct_1d_pkg.sv | 33 +++
 rtl/idct_1d_if.sv | 24 ++
 rtl/idct_mac_lane.sv | 59 +++++
 rtl/idct_1d.sv | 99 +++++++++
 tb/tb_idct_1d.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idct_1d_pkg.sv
// Shared constants, state encoding and the 8x8 inverse-DCT basis table (Q2.14).
package dct_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int DATA_DEPTH  = 8;
    localparam int COEFF_WIDTH = 16;
    localparam int FRAC_BITS   = 14;
    localparam int ROUND_CONST = 1 << (FRAC_BITS - 1);
    localparam int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3;
    localparam int K_WIDTH     = $clog2(DATA_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

    // B_TABLE[n][k] = round(2^14 * c(k)/2 * cos((2n+1)k*pi/16))
    localparam coeff_t B_TABLE [DATA_DEPTH][DATA_DEPTH] = '{
        '{16'sd5793,  16'sd8035,  16'sd7568,  16'sd6811,  16'sd5793,  16'sd4551,  16'sd3135,  16'sd1598},
        '{16'sd5793,  16'sd6811,  16'sd3135, -16'sd1598, -16'sd5793, -16'sd8035, -16'sd7568, -16'sd4551},
        '{16'sd5793,  16'sd4551, -16'sd3135, -16'sd8035, -16'sd5793,  16'sd1598,  16'sd7568,  16'sd6811},
        '{16'sd5793,  16'sd1598, -16'sd7568, -16'sd4551,  16'sd5793,  16'sd6811, -16'sd3135, -16'sd8035},
        '{16'sd5793, -16'sd1598, -16'sd7568,  16'sd4551,  16'sd5793, -16'sd6811, -16'sd3135,  16'sd8035},
        '{16'sd5793, -16'sd4551, -16'sd3135,  16'sd8035, -16'sd5793, -16'sd1598,  16'sd7568, -16'sd6811},
        '{16'sd5793, -16'sd6811,  16'sd3135,  16'sd1598, -16'sd5793,  16'sd8035, -16'sd7568,  16'sd4551},
        '{16'sd5793, -16'sd8035,  16'sd7568, -16'sd6811,  16'sd5793, -16'sd4551,  16'sd3135, -16'sd1598}
    };

endpackage

// File: rtl/idct_1d_if.sv
// Coefficient-in / sample-out streaming bus of the inverse DCT stage.
interface idct_1d_if;
    import dct_pkg::*;

    // A transfer happens on each clock edge where valid && ready; the source keeps
    // valid and data stable until then and the sink may change ready at any time.
    logic                               in_valid;
    logic                               in_ready;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]   data_in;
    logic                               out_valid;
    logic                               out_ready;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]   data_out;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

endinterface

// File: rtl/idct_mac_lane.sv
// One output lane: full-precision signed accumulator plus round-half-up and saturate.
module idct_mac_lane
    import dct_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_clr,
    input  logic                           i_en,
    input  logic                           i_load,
    input  logic signed [DATA_WIDTH-1:0]   i_x,
    input  coeff_t                         i_b,
    output logic        [DATA_WIDTH-1:0]   o_y
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [DATA_WIDTH-1:0] r_y;
    logic signed [ACC_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]  w_rounded;
    logic signed [ACC_WIDTH-1:0]  w_shifted;
    logic        [DATA_WIDTH-1:0] w_sat;

    assign w_prod    = ACC_WIDTH'(i_x) * ACC_WIDTH'(i_b);
    assign w_rounded = r_acc + ACC_WIDTH'(ROUND_CONST);
    // Arithmetic shift floors toward minus infinity, so -489.9 becomes -490.
    assign w_shifted = w_rounded >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shifted[DATA_WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= r_acc + w_prod;
            end
            if (i_load) begin
                r_y <= w_sat;
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/idct_1d.sv
// 8-point inverse DCT: latches a coefficient vector, runs 8 MAC steps across 8 lanes,
// rounds/saturates, then holds the result until the downstream takes it.
module idct_1d
    import dct_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    idct_1d_if.slave    bus,
    output state_t      o_state
);

    state_t                         r_state;
    state_t                         w_next;
    logic [K_WIDTH-1:0]             r_k;
    logic signed [DATA_WIDTH-1:0]   r_x [DATA_DEPTH];
    logic                           w_accept;
    logic                           w_mac_en;
    logic                           w_load;
    logic [DATA_WIDTH-1:0]          w_y [DATA_DEPTH];
    logic signed [DATA_WIDTH-1:0]   w_x_sel;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_mac_en = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = MAC;
                end
            end
            MAC: begin
                w_mac_en = 1'b1;
                if (r_k == K_WIDTH'(DATA_DEPTH - 1)) begin
                    w_next = ROUND;
                end
            end
            ROUND: begin
                w_load = 1'b1;
                w_next = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_k <= '0;
                for (int i = 0; i < DATA_DEPTH; i++) begin
                    r_x[i] <= bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end else if (w_mac_en) begin
                r_k <= r_k + K_WIDTH'(1);
            end
        end
    end

    assign w_x_sel = r_x[r_k];

    for (genvar n = 0; n < DATA_DEPTH; n++) begin : g_lane
        idct_mac_lane u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_clr  (w_accept),
            .i_en   (w_mac_en),
            .i_load (w_load),
            .i_x    (w_x_sel),
            .i_b    (B_TABLE[n][r_k]),
            .o_y    (w_y[n])
        );
    end

    always_comb begin
        bus.data_out = '0;
        for (int n = 0; n < DATA_DEPTH; n++) begin
            bus.data_out[n*DATA_WIDTH +: DATA_WIDTH] = w_y[n];
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !reset;
    assign bus.out_valid = (r_state == HOLD);
    assign o_state       = r_state;

endmodule

// File: tb/tb_idct_1d.sv
// Self-checking bench for idct_1d: real-valued basis model, expected-result queue, monitor.
module tb_idct_1d;
  import dct_pkg::*;

  localparam int VW = DATA_WIDTH * DATA_DEPTH;
  localparam int TIMEOUT = 300;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  idct_1d_if bus();

  idct_1d dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mon_exp;
  int basis[8][8];
  int out_seen = 0;
  int t0 = 0;
  bit rand_bp = 1'b0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Reference: real-valued basis rounded to nearest, then integer inverse transform.
  task automatic build_basis();
    real pi, ck, val;
    pi = 3.14159265358979323846;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 8; k++) begin
        ck = (k == 0) ? (1.0 / $sqrt(2.0)) : 1.0;
        val = 16384.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        if (val >= 0.0) basis[n][k] = int'($floor(val + 0.5));
        else basis[n][k] = -int'($floor(-val + 0.5));
      end
    end
  endtask

  function automatic logic [VW-1:0] model(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    longint acc, y;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        acc += longint'($signed(v[k*32 +: 32])) * longint'(basis[n][k]);
      end
      y = (acc + 8192) >>> 14;
      if (y > 64'sd2147483647) y = 64'sd2147483647;
      if (y < -64'sd2147483648) y = -64'sd2147483648;
      r[n*32 +: 32] = y[31:0];
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got %0h required no output", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        for (int n = 0; n < 8; n++) begin
          check($sformatf("lane%0d", n), VW'(bus.data_out[n*32 +: 32]), VW'(mon_exp[n*32 +: 32]));
        end
      end
    end
  end

  // Random sink backpressure, active only in the random phase.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (all start and end at posedge+#1) ----------------
  task automatic send(input logic [VW-1:0] v, input bit expect_out);
    int w;
    if (expect_out) exp_q.push_back(model(v));
    bus.data_in = v;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < TIMEOUT) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= TIMEOUT) check("send_timeout", VW'(w), VW'(0));
    @(posedge clk); #1;
    t0 = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int w;
    w = 0;
    while (!bus.out_valid && w < TIMEOUT) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= TIMEOUT) check("out_valid_timeout", VW'(w), VW'(0));
    lat = cyc - t0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!bus.in_ready && w < TIMEOUT) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= TIMEOUT) check("idle_timeout", VW'(w), VW'(0));
  endtask

  function automatic logic [VW-1:0] fill(input logic [31:0] x);
    logic [VW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = x;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  logic [VW-1:0] dc_v, ac_v, va, vb, ea, vr;
  int lat;
  int seen_before;
  bit spurious;

  initial begin
    build_basis();
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    dc_v = '0; dc_v[31:0] = 32'd100;
    ac_v = '0; ac_v[63:32] = 32'd1000;

    // Reset values, and no acceptance while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", VW'(bus.out_valid), VW'(0));
    check("rst_data_out", bus.data_out, VW'(0));
    check("rst_in_ready", VW'(bus.in_ready), VW'(0));
    bus.in_valid = 1'b1;
    bus.data_in = dc_v;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_accept", VW'(dbg_state), VW'(IDLE));
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("in_ready_after_release", VW'(bus.in_ready), VW'(1));
    @(posedge clk); #1;

    // DC only: latency and flat output.
    bus.out_ready = 1'b1;
    send(dc_v, 1'b1);
    wait_valid(lat);
    check("dc_latency", VW'(lat), VW'(9));
    for (int n = 0; n < 8; n++) check($sformatf("dc_x%0d", n), VW'(bus.data_out[n*32 +: 32]), VW'(35));
    wait_idle();

    // Single AC term: rounding symmetry at both ends.
    send(ac_v, 1'b1);
    wait_valid(lat);
    check("ac_x0", VW'(bus.data_out[31:0]), VW'(490));
    check("ac_x7", VW'(bus.data_out[255:224]), VW'(32'hFFFF_FE16));
    wait_idle();

    // Saturation at both rails.
    send(fill(32'h7FFF_FFFF), 1'b1);
    wait_valid(lat);
    check("sat_pos_x0", VW'(bus.data_out[31:0]), VW'(32'h7FFF_FFFF));
    wait_idle();
    send(fill(32'h8000_0000), 1'b1);
    wait_valid(lat);
    check("sat_neg_x0", VW'(bus.data_out[31:0]), VW'(32'h8000_0000));
    wait_idle();

    // Backpressure: result held, second vector refused until handshake.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      va[k*32 +: 32] = $urandom;
      vb[k*32 +: 32] = 32'(int'($urandom_range(0, 20000)) - 10000);
    end
    ea = model(va);
    send(va, 1'b1);
    wait_valid(lat);
    bus.data_in = vb;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(vb));
    for (int i = 0; i < 20; i++) begin
      check("bp_data_stable", bus.data_out, ea);
      check("bp_in_ready", VW'(bus.in_ready), VW'(0));
      check("bp_state_hold", VW'(dbg_state), VW'(HOLD));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", VW'(bus.in_ready), VW'(1));
    @(posedge clk); #1;
    check("bp_second_accepted", VW'(dbg_state), VW'(MAC));
    bus.in_valid = 1'b0;
    wait_valid(lat);
    wait_idle();

    // Mid-operation reset at k=4.
    for (int k = 0; k < 8; k++) vr[k*32 +: 32] = $urandom;
    send(vr, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_mac", VW'(dbg_state), VW'(MAC));
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_state", VW'(dbg_state), VW'(IDLE));
    check("abort_out_valid", VW'(bus.out_valid), VW'(0));
    check("abort_data_out", bus.data_out, VW'(0));
    reset = 1'b0;
    seen_before = out_seen;
    spurious = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious = 1'b1;
    end
    check("abort_no_output", VW'(spurious), VW'(0));
    send(dc_v, 1'b1);
    wait_valid(lat);
    for (int n = 0; n < 8; n++) check($sformatf("post_abort_x%0d", n), VW'(bus.data_out[n*32 +: 32]), VW'(35));
    wait_idle();
    check("abort_output_count", VW'(out_seen - seen_before), VW'(1));

    // Randomized vectors with random sink stalls.
    rand_bp = 1'b1;
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) == 0) vr[k*32 +: 32] = $urandom;
        else vr[k*32 +: 32] = 32'(int'($urandom_range(0, 4000)) - 2000);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      send(vr, 1'b1);
      wait_valid(lat);
      check("rand_latency", VW'(lat), VW'(9));
      wait_idle();
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Final report.
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", VW'(exp_q.size()), VW'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
